alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Request channel between an instruction sequencer (master) and alu_issue (slave).
// Also carries the shared ALU width/opcode/flag-position macros.
`ifndef ALU_ISSUE_DEFS
`define ALU_ISSUE_DEFS
`define REG_WIDTH 8
`define OPP_WIDTH 4
`define SUM   4'h0
`define AND   4'h1
`define OR    4'h2
`define XOR   4'h3
`define SR    4'h4
`define CARRY 0
`define ZERO  1
`define NEG   7
`endif

interface alu_issue_if;
    logic                  req_valid;
    logic                  req_ready;
    logic [`OPP_WIDTH-1:0] req_func;
    logic [`REG_WIDTH-1:0] req_a;
    logic [`REG_WIDTH-1:0] req_b;
    logic [1:0]            req_dst;

    modport master (
        output req_valid, req_func, req_a, req_b, req_dst,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_func, req_a, req_b, req_dst,
        output req_ready
    );
endinterface

// File: rtl/alu_issue.sv
// Issues one operation at a time to a handshaked ALU and writes back result and flags.
// Optional feature: define ALU_ISSUE_TIMEOUT_EN to enable the handshake timeout and err flag.
`ifndef ALU_ISSUE_DEFS
`define ALU_ISSUE_DEFS
`define REG_WIDTH 8
`define OPP_WIDTH 4
`define SUM   4'h0
`define AND   4'h1
`define OR    4'h2
`define XOR   4'h3
`define SR    4'h4
`define CARRY 0
`define ZERO  1
`define NEG   7
`endif

module alu_issue #(
    parameter int                    TIMEOUT_CYCLES = 8,
    parameter logic [`OPP_WIDTH-1:0] IDLE_FUNC      = {`OPP_WIDTH{1'b1}}
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    alu_issue_if.slave            req,
    output logic [`REG_WIDTH-1:0] alu_a,
    output logic [`REG_WIDTH-1:0] alu_b,
    output logic [`OPP_WIDTH-1:0] alu_func,
    output logic [`REG_WIDTH-1:0] alu_status_in,
    input  logic [`REG_WIDTH-1:0] alu_dout,
    input  logic [`REG_WIDTH-1:0] alu_status_out,
    input  logic                  alu_wout,
    output logic                  wb_valid,
    output logic [1:0]            wb_dst,
    output logic [`REG_WIDTH-1:0] wb_data,
    output logic [`REG_WIDTH-1:0] status_reg,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GAP
    } state_t;

    state_t     state;
    logic [1:0] dst;

    // Flag bits the issuer does not own are read only for their own sake.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, alu_status_out, err_clr};

    assign req.req_ready = (state == IDLE);

`ifdef ALU_ISSUE_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_hit;

    // Counter holds cycles already spent, so this is the cycle that reaches the limit.
    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            dst           <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_func      <= IDLE_FUNC;
            alu_status_in <= '0;
            wb_valid      <= 1'b0;
            wb_dst        <= '0;
            wb_data       <= '0;
            status_reg    <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            err           <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            // NOTE: a timeout later in this block overrides this clear, since the last non-blocking write wins.
            if (err_clr) err <= 1'b0;
            if (state != IDLE) tmo_cnt <= tmo_cnt + 8'd1;
`endif
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        alu_a         <= req.req_a;
                        alu_b         <= req.req_b;
                        alu_func      <= req.req_func;
                        dst           <= req.req_dst;
                        alu_status_in <= status_reg;
                        state         <= WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end

                WAIT: begin
                    if (alu_wout) begin
                        wb_valid <= 1'b1;
                        wb_data  <= alu_dout;
                        wb_dst   <= dst;
                        alu_func <= IDLE_FUNC;
                        status_reg[`ZERO] <= alu_status_out[`ZERO];
                        status_reg[`NEG]  <= alu_status_out[`NEG];
                        if (alu_func == `SUM || alu_func == `SR)
                            status_reg[`CARRY] <= alu_status_out[`CARRY];
                        state <= GAP;
`ifdef ALU_ISSUE_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        err      <= 1'b1;
                        alu_func <= IDLE_FUNC;
                        state    <= IDLE;
`endif
                    end
                end

                GAP: begin
                    // Wait for the ALU to drop done so a stale wout cannot complete the next op.
                    if (!alu_wout) begin
                        state <= IDLE;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        err      <= 1'b1;
                        alu_func <= IDLE_FUNC;
                        state    <= IDLE;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
